// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, widths and the fetch-address range check.
package fetch_pkg;
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;
  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  // 33-bit sum so a PC near 2^32 cannot wrap into range
  function automatic logic in_range(input logic [XLEN-1:0] pc, input int unsigned mem_bytes);
    return ({1'b0, pc} + 33'd3) < 33'(mem_bytes);
  endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: memory, decode, redirect and fault signals of the fetch sequencer.
interface fetch_if;
  import fetch_pkg::*;
  logic [XLEN-1:0] imem_pc;
  logic [XLEN-1:0] imem_inst;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic fault;
  logic [XLEN-1:0] fault_pc;
  modport master(output imem_pc, out_valid, out_inst, out_pc, fault, fault_pc,
                 input imem_inst, out_ready, redirect_valid, redirect_pc);
  modport slave(input imem_pc, out_valid, out_inst, out_pc, fault, fault_pc,
                output imem_inst, out_ready, redirect_valid, redirect_pc);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular fetch queue; flush beats push/pop, output holds when empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] hold;
  logic [AW-1:0] wr, rd;
  assign dout = (count != '0) ? mem[rd] : hold;
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      hold <= '0;
    end else begin
      hold <= dout;
      if (flush) begin
        wr <= '0;
        rd <= '0;
        count <= '0;
      end else begin
        wr <= wr + AW'(push);
        rd <= rd + AW'(pop);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer feeding a fetch queue, with redirect and address-fault handling.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2,
  parameter int unsigned MEM_BYTES = 1600
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_n;
  logic [XLEN-1:0] fetch_pc, pc_n, fault_pc_q, fault_pc_n;
  logic fault_q, fault_n, push, pop;
  logic [CW-1:0] count;
  logic [2*XLEN-1:0] dout;
  wire legal_target = (bus.redirect_pc[1:0] == 2'b00) && in_range(bus.redirect_pc, MEM_BYTES);
  assign bus.imem_pc = fetch_pc;
  assign bus.out_valid = count != '0;
  assign {bus.out_pc, bus.out_inst} = dout;
  assign bus.fault = fault_q;
  assign bus.fault_pc = fault_pc_q;
  assign pop = bus.out_valid && bus.out_ready;
  always_comb begin
    state_n = state;
    pc_n = fetch_pc;
    fault_n = fault_q;
    fault_pc_n = fault_pc_q;
    push = 1'b0;
    if (bus.redirect_valid) begin
      pc_n = bus.redirect_pc;
      state_n = legal_target ? RUN : FAULT;
      fault_n = !legal_target;
      fault_pc_n = legal_target ? fault_pc_q : bus.redirect_pc;
    end else if (state == RUN) begin
      if (!in_range(fetch_pc, MEM_BYTES)) begin
        state_n = FAULT;
        fault_n = 1'b1;
        fault_pc_n = fetch_pc;
      end else if ((count < CW'(DEPTH)) || pop) begin
        push = 1'b1;
        pc_n = fetch_pc + XLEN'(INST_BYTES);
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      fault_q <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state <= state_n;
      fetch_pc <= pc_n;
      fault_q <= fault_n;
      fault_pc_q <= fault_pc_n;
    end
  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(bus.redirect_valid),
    .din({fetch_pc, bus.imem_inst}),
    .dout(dout),
    .count(count)
  );
endmodule
